// File: rtl/johnson_seq_ctrl.sv
// rtl/johnson_seq_ctrl.sv - step-counted Johnson/ring shift sequencer with preset, hold and sticky illegal-state flag
// Runs a captured number of Johnson or ring shifts, self-correcting any illegal pattern back to 4'b1000.

module johnson_seq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       seed,
   input  logic       mode,
   input  logic [3:0] steps,
   input  logic       hold,
   input  logic       load,
   input  logic [3:0] din,
   output logic [3:0] Q,
   output logic [3:0] Qbar,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] SEED_VAL = 4'b1000;

   state_t     state_q;
   logic [3:0] q_q;
   logic [3:0] cnt_q;
   logic       mode_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;

   logic       legal_d;
   logic [3:0] shift_d;
   logic [3:0] q_step_d;

   // Johnson states are exactly the patterns with at most one adjacent-bit transition.
   function automatic logic johnson_legal(input logic [3:0] v);
      logic [2:0] t;
      t = v[3:1] ^ v[2:0];
      return $onehot0(t);
   endfunction

   always_comb begin
      legal_d  = mode_q ? $onehot(q_q) : johnson_legal(q_q);
      shift_d  = mode_q ? {q_q[0], q_q[3:1]} : {~q_q[0], q_q[3:1]};
      q_step_d = legal_d ? shift_d : SEED_VAL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         q_q     <= 4'b0000;
         cnt_q   <= 4'd0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  cnt_q  <= steps;
                  err_q  <= 1'b0;
                  if (seed) begin
                     q_q <= SEED_VAL;
                  end
                  if (steps != 4'd0) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else if (load) begin
                  q_q <= din;
               end
            end
            ST_RUN: begin
               if (!hold) begin
                  q_q   <= q_step_d;
                  cnt_q <= cnt_q - 4'd1;
                  if (!legal_d) begin
                     err_q <= 1'b1;
                  end
                  if (cnt_q == 4'd1) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Q    = q_q;
   assign Qbar = ~q_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb/tb_johnson_seq_ctrl.sv - directed and randomized checks of johnson_seq_ctrl against a sequence-table model
module tb_johnson_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start, seed, mode, hold, load;
   logic [3:0] steps, din;
   logic [3:0] Q, Qbar;
   logic       busy, done, err;

   int total = 0;
   int bad   = 0;

   johnson_seq_ctrl dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .seed (seed),
      .mode (mode),
      .steps(steps),
      .hold (hold),
      .load (load),
      .din  (din),
      .Q    (Q),
      .Qbar (Qbar),
      .busy (busy),
      .done (done),
      .err  (err)
   );

   always #5 clk = ~clk;

   // Reference: phase 0=idle 1=running 2=finishing; next values come from the listed sequences.
   int         m_phase;
   logic [3:0] m_q;
   int         m_left;
   logic       m_mode;
   logic       m_err;

   logic [3:0] jseq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
   logic [3:0] rseq [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_q = 4'b0000; m_left = 0; m_mode = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_next(input logic md, input logic [3:0] cur, output logic [3:0] nq, output bit ok);
      ok = 0;
      nq = 4'b1000;
      if (md) begin
         for (int i = 0; i < 4; i++)
            if (rseq[i] == cur) begin ok = 1; nq = rseq[(i + 1) % 4]; end
      end else begin
         for (int i = 0; i < 8; i++)
            if (jseq[i] == cur) begin ok = 1; nq = jseq[(i + 1) % 8]; end
      end
   endtask

   task automatic model_step();
      logic [3:0] nq;
      bit ok;
      if (rst) begin
         model_reset();
      end else if (m_phase == 0) begin
         if (start) begin
            m_mode = mode; m_left = steps; m_err = 1'b0;
            if (seed) m_q = 4'b1000;
            m_phase = (steps != 0) ? 1 : 2;
         end else if (load) begin
            m_q = din;
         end
      end else if (m_phase == 1) begin
         if (!hold) begin
            model_next(m_mode, m_q, nq, ok);
            m_q = nq;
            if (!ok) m_err = 1'b1;
            m_left = m_left - 1;
            if (m_left == 0) m_phase = 2;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".Q"},    {4'h0, Q},    {4'h0, m_q});
      chk({tag, ".Qbar"}, {4'h0, Qbar}, {4'h0, ~m_q});
      chk({tag, ".busy"}, {7'h0, busy}, {7'h0, m_phase == 1});
      chk({tag, ".done"}, {7'h0, done}, {7'h0, m_phase == 2});
      chk({tag, ".err"},  {7'h0, err},  {7'h0, m_err});
   endtask

   task automatic idle_inputs();
      start = 0; seed = 0; mode = 0; steps = 0; hold = 0; load = 0; din = 0;
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic go(input logic sd, input logic md, input logic [3:0] n);
      start = 1; seed = sd; mode = md; steps = n;
      cycle("start");
      idle_inputs();
   endtask

   task automatic async_reset();
      #2 rst = 1;
      #1;
      model_reset();
      check_all("async_rst");
      start = 1; seed = 1; steps = 4'd3;
      cycle("in_rst");
      rst = 0;
      idle_inputs();
   endtask

   int bcnt;

   initial begin
      idle_inputs();
      model_reset();
      #1 rst = 1;
      #1 check_all("reset");
      cycle("reset_hold");
      rst = 0;
      cycle("post_reset");

      // three Johnson shifts from seed
      go(1, 0, 4'd3);
      repeat (4) cycle("j3");
      chk("j3_final", {4'h0, Q}, 8'h0F);

      // full Johnson loop returns to seed
      go(1, 0, 4'd8);
      repeat (9) cycle("j8");
      chk("j8_final", {4'h0, Q}, 8'h08);
      chk("j8_err", {7'h0, err}, 8'h00);

      // ring wraps past 0001
      go(1, 1, 4'd5);
      repeat (6) cycle("r5");
      chk("r5_final", {4'h0, Q}, 8'h04);

      // illegal preset corrected, err sticky until next start
      load = 1; din = 4'b0101;
      cycle("load");
      idle_inputs();
      go(0, 0, 4'd2);
      cycle("ill1");
      chk("ill1_q", {4'h0, Q}, 8'h08);
      chk("ill1_err", {7'h0, err}, 8'h01);
      cycle("ill2");
      chk("ill2_q", {4'h0, Q}, 8'h0C);
      cycle("ill_idle");
      chk("ill_err_sticky", {7'h0, err}, 8'h01);
      go(1, 0, 4'd0);
      chk("err_cleared", {7'h0, err}, 8'h00);
      cycle("z_idle");

      // hold stretches busy by the held cycles
      go(1, 0, 4'd6);
      bcnt = busy ? 1 : 0;
      for (int i = 0; i < 14; i++) begin
         hold = (i >= 2 && i < 5);
         cycle("hold");
         if (busy) bcnt++;
      end
      hold = 0;
      chk("busy_with_hold", bcnt[7:0], 8'd9);

      // zero steps: straight to done, busy never set
      go(1, 1, 4'd0);
      chk("zero_done", {7'h0, done}, 8'h01);
      chk("zero_busy", {7'h0, busy}, 8'h00);
      cycle("zero_idle");

      // reset mid-run, start ignored while busy
      go(1, 0, 4'd5);
      start = 1; seed = 1; steps = 4'd15; mode = 1;
      cycle("busy_start");
      cycle("busy_start2");
      chk("pre_rst_q", {4'h0, Q}, 8'h0E);
      async_reset();
      chk("rst_q", {4'h0, Q}, 8'h00);
      repeat (3) cycle("after_rst");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 5) == 0);
         seed  = $urandom_range(0, 1);
         mode  = $urandom_range(0, 1);
         steps = 4'($urandom_range(0, 15));
         hold  = ($urandom_range(0, 3) == 0);
         load  = ($urandom_range(0, 4) == 0);
         din   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) == 0) async_reset();
         else cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  input  1  run request; sampled only in IDLE.
REQ-004 SHALL provide: seed  input  1  with start, 1 = load seed 4'b1000 and 0 = continue from current Q.
REQ-005 SHALL provide: mode  input  1  0 = Johnson shift, 1 = ring shift; captured at start.
REQ-006 SHALL provide: steps  input  4  number of shifts to perform (0..15); captured at start.
REQ-007 SHALL provide: hold  input  1  pauses RUN with no shift and no count.
REQ-008 SHALL provide: load  input  1  preset strobe; loads din into Q, honoured in IDLE only.
REQ-009 SHALL provide: din  input  4  preset value.
REQ-010 SHALL provide: Q  output  4  counter state (registered).
REQ-011 SHALL provide: Qbar  output  4  always equals ~Q.
REQ-012 SHALL provide: busy  output  1  high while state is RUN.
REQ-013 SHALL provide: done  output  1  one-cycle completion pulse; high while state is DONE.
REQ-014 SHALL provide: err  output  1  sticky illegal-state flag.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 IDLE with start=1 SHALL, on that edge, capture mode and steps into cnt; load Q=4'b1000 if seed=1, else keep Q; clear err; and go to RUN if steps!=0, else to DONE.
REQ-017 IDLE with load=1 and start=0 SHALL set Q<=din; start=1 SHALL take priority over load.
REQ-018 RUN with hold=0 SHALL shift Q once per edge and decrement cnt by 1; on the edge where cnt goes 1->0 it SHALL go to DONE.
REQ-019 Johnson shift SHALL be Q<={~Q[0],Q[3:1]}, giving the sequence 1000,1100,1110,1111,0111,0011,0001,0000, then wrapping to 1000.
REQ-020 Ring shift SHALL be Q<={Q[0],Q[3:1]}, giving the sequence 1000,0100,0010,0001, then wrapping to 1000.
REQ-021 RUN with hold=1 SHALL freeze Q and cnt, and busy SHALL stay high.
REQ-022 Legality SHALL be checked at every shift edge. Legal in Johnson mode = the 8 states of REQ-019; legal in ring mode = one-hot only.
REQ-023 On an illegal pre-shift Q, that edge SHALL load Q<=4'b1000 instead of shifting, set err=1, and still count as one step.
REQ-024 err SHALL remain 1 until the next accepted start or reset.
REQ-025 DONE SHALL last exactly one cycle (done=1, busy=0) and then return to IDLE; Q SHALL hold its value.
REQ-026 start, load, mode, steps and seed SHALL be ignored outside IDLE.
REQ-027 hold SHALL have no effect in IDLE or DONE.
REQ-028 Latency: with no hold, start accepted at edge k gives final Q at edge k+steps, done=1 in the cycle after that edge, and busy=1 for exactly steps cycles.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force Q=0000, Qbar=1111, state=IDLE, cnt=0, busy=0, done=0, err=0.
REQ-030 rst SHALL override all inputs.
REQ-031 Reset mid-RUN SHALL abort the run, and no done pulse SHALL follow.
REQ-032 Operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-033 Reset, then start=1, seed=1, mode=0, steps=3 -> Q steps 1000,1100,1110,1111; busy=1 for 3 cycles; done=1 for 1 cycle; Q then holds 1111.
REQ-034 start, seed=1, mode=0, steps=8 -> Q walks all 8 Johnson states and ends at 1000; err=0.
REQ-035 start, seed=1, mode=1, steps=5 -> Q steps 1000,0100,0010,0001,1000,0100; done pulses once.
REQ-036 load din=0101, then start, seed=0, mode=0, steps=2 -> first shift edge gives Q=1000 and err=1; second gives Q=1100; err stays 1 after done; next start clears err.
REQ-037 steps=6 run with hold=1 for 3 cycles mid-run -> Q and cnt frozen during hold; done arrives 3 cycles later than without hold. Separately, steps=0 -> Q=seed and done in the next cycle with busy never high.
REQ-038 Assert rst during a run (Q=1110) -> Q=0000 immediately; busy, done and err =0; no done pulse; start is ignored while busy and while rst is high.
